// File: rtl/ibex_ex_wb_pipe_if.sv
// EX-to-writeback handshake bundle for ibex_ex_wb_pipe.
// master: EX producer plus register-file consumer (drives results and wb_ready_i).
// slave : the pipeline stage itself.
interface ibex_ex_wb_pipe_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned RegAddrW  = 5
);
  logic                 ex_valid_i;
  logic                 ex_ready_o;
  logic [DataWidth-1:0] ex_result_i;
  logic [RegAddrW-1:0]  ex_rd_addr_i;
  logic                 ex_rd_we_i;
  logic                 wb_valid_o;
  logic                 wb_ready_i;
  logic                 rf_we_o;
  logic [RegAddrW-1:0]  rf_waddr_o;
  logic [DataWidth-1:0] rf_wdata_o;

  modport master (
    output ex_valid_i, ex_result_i, ex_rd_addr_i, ex_rd_we_i, wb_ready_i,
    input  ex_ready_o, wb_valid_o, rf_we_o, rf_waddr_o, rf_wdata_o
  );

  modport slave (
    input  ex_valid_i, ex_result_i, ex_rd_addr_i, ex_rd_we_i, wb_ready_i,
    output ex_ready_o, wb_valid_o, rf_we_o, rf_waddr_o, rf_wdata_o
  );
endinterface

// File: rtl/ibex_ex_wb_pipe.sv
// EX-to-writeback pipeline stage: two-entry skid buffer (HEAD/SKID) feeding the
// register-file write port, operand forwarding to decode and a retire counter.
// Optional feature macro: IBEX_WB_FWD_EN builds the forwarding comparators;
// without it the forwarding outputs are tied to zero.
module ibex_ex_wb_pipe #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned RegAddrW  = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  ibex_ex_wb_pipe_if.slave     bus,
  input  logic                 flush_i,
  input  logic [RegAddrW-1:0]  fwd_raddr_a_i,
  input  logic [RegAddrW-1:0]  fwd_raddr_b_i,
  output logic                 fwd_hit_a_o,
  output logic                 fwd_hit_b_o,
  output logic [DataWidth-1:0] fwd_data_a_o,
  output logic [DataWidth-1:0] fwd_data_b_o,
  output logic [31:0]          retire_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic                 we;
    logic [RegAddrW-1:0]  rd;
    logic [DataWidth-1:0] data;
  } entry_t;

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  logic   ready_q, valid_q;
  logic [31:0] retire_cnt_q;

  logic   accept, pop;
  entry_t ex_entry;

  assign ex_entry = '{we: bus.ex_rd_we_i, rd: bus.ex_rd_addr_i, data: bus.ex_result_i};
  assign accept   = bus.ex_valid_i & ready_q;
  assign pop      = valid_q & bus.wb_ready_i;

  // Next-state of the occupancy FSM and the two entries.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          head_d  = ex_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          head_d = ex_entry;
        end else if (accept) begin
          skid_d  = ex_entry;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins over everything; a concurrent pop has still been issued this cycle.
    if (flush_i) begin
      state_d = EMPTY;
    end
  end

  // State, entries, registered handshake flags and retire counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: entry payloads are reset too, because rf_waddr_o/rf_wdata_o must read zero out of reset.
    if (!rst_ni) begin
      state_q      <= EMPTY;
      head_q       <= '0;
      skid_q       <= '0;
      ready_q      <= 1'b1;
      valid_q      <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != FULL);
      valid_q <= (state_d != EMPTY);
      if (pop) begin
        retire_cnt_q <= retire_cnt_q + 32'd1;
      end
    end
  end

  assign bus.ex_ready_o = ready_q;
  assign bus.wb_valid_o = valid_q;
  assign bus.rf_we_o    = pop & head_q.we & (|head_q.rd);
  assign bus.rf_waddr_o = head_q.rd;
  assign bus.rf_wdata_o = head_q.data;
  assign retire_cnt_o   = retire_cnt_q;

`ifdef IBEX_WB_FWD_EN
  logic head_vld, skid_vld;
  assign head_vld = (state_q != EMPTY);
  assign skid_vld = (state_q == FULL);

  function automatic logic fwd_match(entry_t e, logic vld, logic [RegAddrW-1:0] addr);
    return vld & e.we & (|e.rd) & (e.rd == addr);
  endfunction

  // Forwarding mux per read port; SKID is younger and overrides HEAD.
  always_comb begin
    fwd_hit_a_o  = 1'b0;
    fwd_data_a_o = '0;
    fwd_hit_b_o  = 1'b0;
    fwd_data_b_o = '0;
    if (fwd_match(head_q, head_vld, fwd_raddr_a_i)) begin
      fwd_hit_a_o  = 1'b1;
      fwd_data_a_o = head_q.data;
    end
    if (fwd_match(skid_q, skid_vld, fwd_raddr_a_i)) begin
      fwd_hit_a_o  = 1'b1;
      fwd_data_a_o = skid_q.data;
    end
    if (fwd_match(head_q, head_vld, fwd_raddr_b_i)) begin
      fwd_hit_b_o  = 1'b1;
      fwd_data_b_o = head_q.data;
    end
    if (fwd_match(skid_q, skid_vld, fwd_raddr_b_i)) begin
      fwd_hit_b_o  = 1'b1;
      fwd_data_b_o = skid_q.data;
    end
  end
`else
  // Forwarding not built: read addresses are deliberately ignored.
  logic unused_fwd_raddr;
  assign unused_fwd_raddr = ^{fwd_raddr_a_i, fwd_raddr_b_i};
  assign fwd_hit_a_o  = 1'b0;
  assign fwd_hit_b_o  = 1'b0;
  assign fwd_data_a_o = '0;
  assign fwd_data_b_o = '0;
`endif

endmodule

// File: tb/tb_ibex_ex_wb_pipe.sv
// Self-checking bench for ibex_ex_wb_pipe: directed steps with a scoreboard
// queue mirroring the two-entry buffer contents.
module tb_ibex_ex_wb_pipe;
  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [AW-1:0] raddr_a, raddr_b;
  logic          hit_a, hit_b;
  logic [DW-1:0] data_a, data_b;
  logic [31:0]   cnt;

  exp_t        sb[$];
  logic [31:0] model_cnt;
  int          checks = 0;
  int          errors = 0;

  ibex_ex_wb_pipe_if #(.DataWidth(DW), .RegAddrW(AW)) bus ();

  ibex_ex_wb_pipe #(.DataWidth(DW), .RegAddrW(AW)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .bus           (bus),
    .flush_i       (flush),
    .fwd_raddr_a_i (raddr_a),
    .fwd_raddr_b_i (raddr_b),
    .fwd_hit_a_o   (hit_a),
    .fwd_hit_b_o   (hit_b),
    .fwd_data_a_o  (data_a),
    .fwd_data_b_o  (data_b),
    .retire_cnt_o  (cnt)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] observed, logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Youngest matching buffered entry wins; returns {hit, data}.
  function automatic logic [DW:0] fwd_model(logic [AW-1:0] addr);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].we && sb[i].rd != '0 && sb[i].rd == addr) return {1'b1, sb[i].data};
    end
    return '0;
  endfunction

  // Called at a negedge with inputs already driven: checks outputs, updates
  // the scoreboard for this cycle's pop/accept/flush, then advances one clock.
  task automatic cycle();
    exp_t          e;
    logic [DW:0]   fa, fb;
    int            occ;
    #1;
    occ = sb.size();
    fa  = fwd_model(raddr_a);
    fb  = fwd_model(raddr_b);
`ifndef IBEX_WB_FWD_EN
    fa = '0;
    fb = '0;
`endif
    check("ex_ready", bus.ex_ready_o, occ < 2);
    check("wb_valid", bus.wb_valid_o, occ != 0);
    check("fwd_hit_a", hit_a, fa[DW]);
    check("fwd_data_a", data_a, fa[DW-1:0]);
    check("fwd_hit_b", hit_b, fb[DW]);
    check("fwd_data_b", data_b, fb[DW-1:0]);
    check("retire_cnt", cnt, model_cnt);
    if (occ != 0) begin
      e = sb[0];
      check("rf_waddr", bus.rf_waddr_o, e.rd);
      check("rf_wdata", bus.rf_wdata_o, e.data);
      if (bus.wb_ready_i) begin
        check("rf_we", bus.rf_we_o, e.we && e.rd != '0);
        void'(sb.pop_front());
        model_cnt++;
      end else begin
        check("rf_we_stall", bus.rf_we_o, 1'b0);
      end
    end else begin
      check("rf_we_idle", bus.rf_we_o, 1'b0);
    end
    if (bus.ex_valid_i && occ < 2 && !flush) begin
      sb.push_back('{we: bus.ex_rd_we_i, rd: bus.ex_rd_addr_i, data: bus.ex_result_i});
    end
    if (flush) sb.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(logic [AW-1:0] rd, logic [DW-1:0] data, logic we);
    bus.ex_valid_i   = 1'b1;
    bus.ex_rd_addr_i = rd;
    bus.ex_result_i  = data;
    bus.ex_rd_we_i   = we;
    cycle();
    bus.ex_valid_i   = 1'b0;
  endtask

  initial begin
    rst_n            = 1'b0;
    flush            = 1'b0;
    raddr_a          = '0;
    raddr_b          = '0;
    bus.ex_valid_i   = 1'b0;
    bus.ex_result_i  = '0;
    bus.ex_rd_addr_i = '0;
    bus.ex_rd_we_i   = 1'b0;
    bus.wb_ready_i   = 1'b0;
    model_cnt        = '0;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_wb_valid", bus.wb_valid_o, 1'b0);
    check("rst_rf_we", bus.rf_we_o, 1'b0);
    check("rst_rf_waddr", bus.rf_waddr_o, '0);
    check("rst_rf_wdata", bus.rf_wdata_o, '0);
    check("rst_ex_ready", bus.ex_ready_o, 1'b1);
    check("rst_fwd_hit_a", hit_a, 1'b0);
    check("rst_fwd_data_b", data_b, '0);
    check("rst_retire_cnt", cnt, '0);
    rst_n = 1'b1;
    repeat (2) cycle();

    // Streaming: 8 results, one write per cycle.
    bus.wb_ready_i = 1'b1;
    raddr_a = 5'd4;
    raddr_b = 5'd7;
    for (int i = 1; i <= 8; i++) push(AW'(i), 32'h100 + DW'(i), 1'b1);
    repeat (2) cycle();
    check("stream_retire_cnt", cnt, 32'd8);

    // Backpressure: fill to FULL, extra result refused, then drain in order.
    bus.wb_ready_i = 1'b0;
    push(5'd3, 32'hAA, 1'b1);
    push(5'd4, 32'hBB, 1'b1);
    check("full_ex_ready", bus.ex_ready_o, 1'b0);
    push(5'd9, 32'hCC, 1'b1);
    check("full_head_held", bus.rf_wdata_o, 32'hAA);
    bus.wb_ready_i = 1'b1;
    repeat (3) cycle();

    // Forwarding priority: SKID (younger) over HEAD for the same rd.
    bus.wb_ready_i = 1'b0;
    raddr_a = 5'd5;
    raddr_b = 5'd0;
    push(5'd5, 32'h11, 1'b1);
    push(5'd5, 32'h22, 1'b1);
    cycle();
`ifdef IBEX_WB_FWD_EN
    check("fwd_skid_hit", hit_a, 1'b1);
    check("fwd_skid_data", data_a, 32'h22);
`else
    check("fwd_off_hit", hit_a, 1'b0);
    check("fwd_off_data", data_a, '0);
`endif
    bus.wb_ready_i = 1'b1;
    repeat (3) cycle();

    // x0 and we=0 entries: never forwarded, never written, still retired.
    bus.wb_ready_i = 1'b0;
    raddr_a = 5'd6;
    raddr_b = 5'd0;
    push(5'd0, 32'h33, 1'b1);
    push(5'd6, 32'h44, 1'b0);
    check("x0_fwd_hit_b", hit_b, 1'b0);
    check("we0_fwd_hit_a", hit_a, 1'b0);
    bus.wb_ready_i = 1'b1;
    repeat (3) cycle();

    // Flush in FULL with concurrent pop and ex_valid; counter near wrap.
    bus.wb_ready_i = 1'b0;
    push(5'd1, 32'h55, 1'b1);
    push(5'd2, 32'h66, 1'b1);
    force dut.retire_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.retire_cnt_q;
    model_cnt = 32'hFFFF_FFFE;
    flush = 1'b1;
    bus.wb_ready_i = 1'b1;
    push(5'd7, 32'h77, 1'b1);
    flush = 1'b0;
    check("flush_wb_valid", bus.wb_valid_o, 1'b0);
    check("flush_cnt", cnt, 32'hFFFF_FFFF);

    // Flush in ONE: the result that would have been accepted is dropped.
    bus.wb_ready_i = 1'b0;
    push(5'd8, 32'h88, 1'b1);
    flush = 1'b1;
    push(5'd9, 32'h99, 1'b1);
    flush = 1'b0;
    check("flush_one_wb_valid", bus.wb_valid_o, 1'b0);

    // Counter wraps to zero on the next pop.
    bus.wb_ready_i = 1'b1;
    push(5'd10, 32'hA0, 1'b1);
    cycle();
    check("cnt_wrap", cnt, 32'd0);

    // Asynchronous reset while FULL.
    bus.wb_ready_i = 1'b0;
    push(5'd11, 32'hB0, 1'b1);
    push(5'd12, 32'hC0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_wb_valid", bus.wb_valid_o, 1'b0);
    check("arst_ex_ready", bus.ex_ready_o, 1'b1);
    check("arst_rf_wdata", bus.rf_wdata_o, '0);
    check("arst_cnt", cnt, '0);
    sb.delete();
    model_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
